// File: rtl/block_emitter.sv
// rtl/block_emitter.sv - begin/end token stream to ASCII character serializer
//
// Turns BEGIN/END/WORD/NOP tokens into the text "begin", "end" or a single
// character, one character per clock, with one space between consecutive
// emitted tokens. Tracks nesting depth and raises a sticky error on
// overflow (BEGIN at maximum depth) or underflow (END at depth 0).
//
// Optional feature macro: END_GUARD_EN
//   defined   - an END at depth 0 is swallowed (no separator, no text)
//   undefined - an END at depth 0 is still emitted as "end"
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-low reset
//   tok_valid  in   token offered
//   tok_ready  out  token accepted this cycle when tok_valid=1
//   tok_type   in   00=BEGIN 01=END 10=WORD 11=NOP
//   tok_char   in   character for WORD tokens
//   out_valid  out  out_char carries a stream character
//   out_char   out  stream character, space when out_valid=0
//   depth      out  nesting depth (lags the accept by one cycle)
//   balanced   out  depth==0 and no error
//   error      out  sticky illegal-sequence flag

module block_emitter #(
    parameter int DEPTH_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tok_valid,
    output logic               tok_ready,
    input  logic [1:0]         tok_type,
    input  logic [7:0]         tok_char,
    output logic               out_valid,
    output logic [7:0]         out_char,
    output logic [DEPTH_W-1:0] depth,
    output logic               balanced,
    output logic               error
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEP  = 2'd1,
        EMIT = 2'd2
    } state_t;

    localparam logic [1:0] T_BEGIN = 2'b00;
    localparam logic [1:0] T_END   = 2'b01;
    localparam logic [1:0] T_WORD  = 2'b10;
    localparam logic [1:0] T_NOP   = 2'b11;

    localparam logic [DEPTH_W-1:0] DEPTH_MAX  = '1;
    localparam logic [DEPTH_W-1:0] DEPTH_ZERO = '0;
    localparam logic [DEPTH_W-1:0] DEPTH_ONE  = {{(DEPTH_W-1){1'b0}}, 1'b1};

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_UNDER = 8'h5F;

    state_t              state_q, state_d;
    logic [1:0]          type_q, type_d;
    logic [7:0]          char_q, char_d;
    logic [2:0]          idx_q, idx_d;
    logic                started_q, started_d;
    // level/err_now reflect the latest accept immediately; depth/error are
    // their one-cycle-delayed copies so they move with the first character.
    logic [DEPTH_W-1:0]  level_q, level_d;
    logic                err_now_q, err_now_d;
    logic [DEPTH_W-1:0]  depth_q, depth_d;
    logic                error_q, error_d;
    logic                out_valid_q, out_valid_d;
    logic [7:0]          out_char_q, out_char_d;

    logic                last_char;
    logic                ready_w;
    logic                accept;
    logic                drop_end;
    logic                emit_new;

    function automatic logic [2:0] last_idx(input logic [1:0] t);
        logic [2:0] r;
        case (t)
            T_BEGIN: r = 3'd4;
            T_END:   r = 3'd2;
            default: r = 3'd0;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] tok_text(input logic [1:0] t,
                                            input logic [7:0] c,
                                            input logic [2:0] i);
        logic [7:0] r;
        r = CH_SPACE;
        case (t)
            T_BEGIN: begin
                case (i)
                    3'd0:    r = 8'h62; // b
                    3'd1:    r = 8'h65; // e
                    3'd2:    r = 8'h67; // g
                    3'd3:    r = 8'h69; // i
                    default: r = 8'h6E; // n
                endcase
            end
            T_END: begin
                case (i)
                    3'd0:    r = 8'h65; // e
                    3'd1:    r = 8'h6E; // n
                    default: r = 8'h64; // d
                endcase
            end
            // A literal space would be read as a separator downstream.
            T_WORD:  r = (c == CH_SPACE) ? CH_UNDER : c;
            default: r = CH_SPACE;
        endcase
        return r;
    endfunction

    always_comb begin
        last_char = (state_q == EMIT) && (idx_q == last_idx(type_q));
        ready_w   = (state_q == IDLE) || last_char;
        accept    = tok_valid && ready_w;
`ifdef END_GUARD_EN
        drop_end  = (tok_type == T_END) && (level_q == DEPTH_ZERO);
`else
        drop_end  = 1'b0;
`endif
        emit_new  = accept && (tok_type != T_NOP) && !drop_end;
    end

    always_comb begin
        state_d     = state_q;
        type_d      = type_q;
        char_d      = char_q;
        idx_d       = idx_q;
        started_d   = started_q;
        level_d     = level_q;
        err_now_d   = err_now_q;
        depth_d     = level_q;
        error_d     = err_now_q;
        out_valid_d = (state_q != IDLE);
        out_char_d  = CH_SPACE;

        if (state_q == SEP) begin
            out_char_d = CH_SPACE;
        end else if (state_q == EMIT) begin
            out_char_d = tok_text(type_q, char_q, idx_q);
        end

        if (accept) begin
            case (tok_type)
                T_BEGIN: begin
                    if (level_q == DEPTH_MAX) err_now_d = 1'b1;
                    else                      level_d   = level_q + DEPTH_ONE;
                end
                T_END: begin
                    if (level_q == DEPTH_ZERO) err_now_d = 1'b1;
                    else                       level_d   = level_q - DEPTH_ONE;
                end
                default: ;
            endcase
        end

        if (emit_new) begin
            type_d    = tok_type;
            char_d    = tok_char;
            idx_d     = 3'd0;
            started_d = 1'b1;
            state_d   = started_q ? SEP : EMIT;
        end else begin
            case (state_q)
                SEP: begin
                    state_d = EMIT;
                    idx_d   = 3'd0;
                end
                EMIT: begin
                    if (last_char) state_d = IDLE;
                    else           idx_d   = idx_q + 3'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            type_q      <= T_NOP;
            char_q      <= CH_SPACE;
            idx_q       <= 3'd0;
            started_q   <= 1'b0;
            level_q     <= DEPTH_ZERO;
            err_now_q   <= 1'b0;
            depth_q     <= DEPTH_ZERO;
            error_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_char_q  <= CH_SPACE;
        end else begin
            state_q     <= state_d;
            type_q      <= type_d;
            char_q      <= char_d;
            idx_q       <= idx_d;
            started_q   <= started_d;
            level_q     <= level_d;
            err_now_q   <= err_now_d;
            depth_q     <= depth_d;
            error_q     <= error_d;
            out_valid_q <= out_valid_d;
            out_char_q  <= out_char_d;
        end
    end

    assign tok_ready = ready_w;
    assign out_valid = out_valid_q;
    assign out_char  = out_char_q;
    assign depth     = depth_q;
    assign error     = error_q;
    assign balanced  = (depth_q == DEPTH_ZERO) && !error_q;

endmodule

// File: tb/tb_block_emitter.sv
// tb/tb_block_emitter.sv - self-checking bench for block_emitter

module tb_block_emitter;

    localparam int DW   = 2;
    localparam int DMAX = (1 << DW) - 1;

    logic          clk;
    logic          reset;
    logic          tok_valid;
    logic          tok_ready;
    logic [1:0]    tok_type;
    logic [7:0]    tok_char;
    logic          out_valid;
    logic [7:0]    out_char;
    logic [DW-1:0] depth;
    logic          balanced;
    logic          error;

    block_emitter #(.DEPTH_W(DW)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .tok_valid (tok_valid),
        .tok_ready (tok_ready),
        .tok_type  (tok_type),
        .tok_char  (tok_char),
        .out_valid (out_valid),
        .out_char  (out_char),
        .depth     (depth),
        .balanced  (balanced),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: expected character stream plus depth/error state.
    logic [7:0] q[$];
    int         m_depth;
    bit         m_err;
    bit         m_started;
    int         vis_depth;
    bit         vis_err;
    string      got;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_str(input string tag, input string obs, input string exp);
        logic [7:0] a;
        logic [7:0] b;
        check({tag, "_len"}, obs.len(), exp.len());
        for (int i = 0; i < exp.len() && i < obs.len(); i++) begin
            a = obs[i];
            b = exp[i];
            check(tag, a, b);
        end
    endtask

    task automatic model_accept(input logic [1:0] t, input logic [7:0] c);
        string txt;
        bit    emit;
        logic [7:0] ch;
        emit = 1'b1;
        txt  = "";
        case (t)
            2'b00: begin
                txt = "begin";
                if (m_depth == DMAX) m_err = 1'b1;
                else                 m_depth++;
            end
            2'b01: begin
                txt = "end";
                if (m_depth == 0) begin
                    m_err = 1'b1;
`ifdef END_GUARD_EN
                    emit = 1'b0;
`endif
                end else begin
                    m_depth--;
                end
            end
            2'b10: txt = $sformatf("%c", (c == 8'h20) ? 8'h5F : c);
            default: emit = 1'b0;
        endcase
        if (emit) begin
            if (m_started) q.push_back(8'h20);
            for (int i = 0; i < txt.len(); i++) begin
                ch = txt[i];
                q.push_back(ch);
            end
            m_started = 1'b1;
        end
    endtask

    // One clock: drive at negedge, model the accept, check after posedge.
    task automatic step(input logic v, input logic [1:0] t, input logic [7:0] c,
                        input logic rst_n, output bit acc);
        bit         exp_v;
        logic [7:0] exp_c;
        @(negedge clk);
        reset     = rst_n;
        tok_valid = v;
        tok_type  = t;
        tok_char  = c;
        #1;
        if (rst_n) check("tok_ready", tok_ready, (q.size() <= 1) ? 1 : 0);
        acc   = rst_n && v && tok_ready;
        exp_v = rst_n && (q.size() != 0);
        exp_c = exp_v ? q.pop_front() : 8'h20;
        if (!rst_n) begin
            q.delete();
            m_depth   = 0;
            m_err     = 1'b0;
            m_started = 1'b0;
            vis_depth = 0;
            vis_err   = 1'b0;
        end else if (acc) begin
            model_accept(t, c);
        end
        @(posedge clk);
        #1;
        check("out_valid", out_valid, exp_v);
        check("out_char", out_char, exp_c);
        check("depth", depth, vis_depth);
        check("error", error, vis_err);
        check("balanced", balanced, (vis_depth == 0 && !vis_err) ? 1 : 0);
        vis_depth = m_depth;
        vis_err   = m_err;
        if (out_valid) got = $sformatf("%s%c", got, out_char);
    endtask

    task automatic do_reset();
        bit acc;
        repeat (2) step(1'b0, 2'b11, 8'h20, 1'b0, acc);
        got = "";
    endtask

    task automatic send(input logic [1:0] t, input logic [7:0] c);
        bit acc;
        acc = 1'b0;
        for (int n = 0; n < 40 && !acc; n++) step(1'b1, t, c, 1'b1, acc);
        if (!acc) check("send_timeout", 0, 1);
    endtask

    task automatic drain();
        bit acc;
        int n;
        n = 0;
        while (q.size() != 0 && n < 60) begin
            step(1'b0, 2'b11, 8'h20, 1'b1, acc);
            n++;
        end
        step(1'b0, 2'b11, 8'h20, 1'b1, acc);
        if (q.size() != 0) check("drain_timeout", q.size(), 0);
    endtask

    initial begin
        bit acc;
        reset     = 1'b0;
        tok_valid = 1'b0;
        tok_type  = 2'b11;
        tok_char  = 8'h20;
        m_depth   = 0;
        m_err     = 1'b0;
        m_started = 1'b0;
        vis_depth = 0;
        vis_err   = 1'b0;
        got       = "";

        // Reset state
        do_reset();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_char", out_char, 8'h20);
        check("rst_depth", depth, 0);
        check("rst_balanced", balanced, 1);

        // BEGIN, WORD x, END back-to-back
        send(2'b00, 8'h00);
        send(2'b10, 8'h78);
        send(2'b01, 8'h00);
        drain();
        check_str("seq_bxe", got, "begin x end");
        check("seq_bxe_depth", depth, 0);
        check("seq_bxe_bal", balanced, 1);

        // BEGIN, BEGIN, END
        do_reset();
        send(2'b00, 8'h00);
        send(2'b00, 8'h00);
        send(2'b01, 8'h00);
        drain();
        check_str("seq_bbe", got, "begin begin end");
        check("seq_bbe_depth", depth, 1);
        check("seq_bbe_bal", balanced, 0);
        check("seq_bbe_err", error, 0);

        // END at depth 0
        do_reset();
        send(2'b01, 8'h00);
        drain();
`ifdef END_GUARD_EN
        check_str("end0", got, "");
`else
        check_str("end0", got, "end");
`endif
        check("end0_err", error, 1);
        check("end0_depth", depth, 0);
        check("end0_bal", balanced, 0);

        // Saturation at maximum depth, plus a space-as-word substitution
        do_reset();
        repeat (4) send(2'b00, 8'h00);
        send(2'b10, 8'h20);
        drain();
        check_str("sat", got, "begin begin begin begin _");
        check("sat_depth", depth, DMAX);
        check("sat_err", error, 1);

        // Reset during the third character of "begin"
        do_reset();
        send(2'b00, 8'h00);
        for (int n = 0; n < 20 && got.len() < 3; n++) step(1'b0, 2'b11, 8'h20, 1'b1, acc);
        check("mid_len", got.len(), 3);
        step(1'b0, 2'b11, 8'h20, 1'b0, acc);
        check("mid_out_valid", out_valid, 0);
        check("mid_depth", depth, 0);
        got = "";
        send(2'b00, 8'h00);
        drain();
        check_str("mid_after", got, "begin");

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            logic       v;
            logic [1:0] t;
            logic [7:0] c;
            logic       r;
            v = ($urandom_range(0, 3) != 0);
            t = 2'($urandom_range(0, 3));
            c = 8'($urandom_range(8'h20, 8'h7E));
            r = ($urandom_range(0, 99) != 0);
            step(v, t, c, r, acc);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
